// File: rtl/flex_down_timer.sv
// Programmable down-counter with one-shot / auto-reload modes, pause and abort.
// Latency: count_out = load_val one edge after an accepted start; expire is a registered pulse.
// Backpressure: none; pause freezes the count in RUN, abort returns to IDLE from any state.
module flex_down_timer #(
  parameter int NUM_CNT_BITS = 7
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    periodic,
  input  logic                    pause,
  input  logic                    abort,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    busy,
  output logic                    done,
  output logic                    expire,
  output logic [7:0]              expire_total
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [NUM_CNT_BITS-1:0] reload_val;
  logic                    reload_mode;

  // Status flags come straight from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Control FSM, counter, expire pulse and saturating expiration total.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      count_out    <= '0;
      expire       <= 1'b0;
      expire_total <= 8'd0;
      reload_val   <= '0;
      reload_mode  <= 1'b0;
    end else begin
      // expire is a single-cycle pulse unless a terminal count re-asserts it below.
      expire <= 1'b0;
      if (abort) begin
        // Total is deliberately kept so software can read it after an abort.
        state     <= IDLE;
        count_out <= '0;
      end else if (start && (state != RUN)) begin
        if (load_val != '0) begin
          state        <= RUN;
          count_out    <= load_val;
          reload_val   <= load_val;
          reload_mode  <= periodic;
          expire_total <= 8'd0;
        end else begin
          // A zero load expires immediately, whatever the mode.
          state        <= DONE;
          count_out    <= '0;
          expire       <= 1'b1;
          expire_total <= 8'd1;
        end
      end else if ((state == RUN) && !pause) begin
        if (count_out > CNT_ONE) begin
          count_out <= count_out - CNT_ONE;
        end else begin
          // Terminal count: count_out is 1 here, RUN never holds zero.
          expire <= 1'b1;
          if (expire_total != 8'hFF) begin
            expire_total <= expire_total + 8'd1;
          end
          if (reload_mode) begin
            count_out <= reload_val;
          end else begin
            count_out <= '0;
            state     <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: doc/flex_down_timer.md
FLEX_DOWN_TIMER -- requirements
Module: flex_down_timer

Interface
REQ-001 The block SHALL have parameter NUM_CNT_BITS, default 7, giving the width of the counter and reload value.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, which requests loading of load_val and begins counting.
REQ-005 The block SHALL have port load_val, input, NUM_CNT_BITS, the start/reload value, sampled only when start is accepted.
REQ-006 The block SHALL have port periodic, input, 1, selecting auto-reload when 1 and one-shot when 0, sampled only when start is accepted.
REQ-007 The block SHALL have port pause, input, 1, which holds the count while high.
REQ-008 The block SHALL have port abort, input, 1, which returns the block to IDLE.
REQ-009 The block SHALL have port count_out, output, NUM_CNT_BITS, the current count (registered).
REQ-010 The block SHALL have port busy, output, 1, high in RUN.
REQ-011 The block SHALL have port done, output, 1, high in DONE.
REQ-012 The block SHALL have port expire, output, 1, a registered one-cycle pulse per terminal count.
REQ-013 The block SHALL have port expire_total, output, 8, a saturating count of expirations since the last accepted start.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE), both decoded from the state register.
REQ-015 Priority SHALL be, highest first: n_rst, then abort, then start, then pause, then decrement.
REQ-016 abort=1 in any state SHALL, at the next edge, give state IDLE, count_out=0, expire=0; expire_total SHALL be held.
REQ-017 start=1 in IDLE or DONE with load_val!=0 SHALL, at the next edge, give count_out=load_val, state RUN, and latch the reload value and the periodic mode, with expire_total=0.
REQ-018 start=1 in IDLE or DONE with load_val==0 SHALL, at the next edge, give state DONE, count_out=0, expire=1 and expire_total=1, regardless of periodic.
REQ-019 start=1 in RUN SHALL be ignored; counting continues unchanged.
REQ-020 In RUN with pause=0 and count_out>1, count_out SHALL decrement by 1 per cycle.
REQ-021 In RUN with pause=0, count_out==1 and latched mode one-shot, the next edge SHALL give count_out=0, state DONE and expire=1.
REQ-022 In RUN with pause=0, count_out==1 and latched mode periodic, the next edge SHALL give count_out=the latched reload value, keep state RUN, and give expire=1.
REQ-023 The expire pulse SHALL last exactly one cycle; expire SHALL be 0 in every other cycle.
REQ-024 expire_total SHALL increment in the same edge that sets expire and SHALL saturate at 255.
REQ-025 In RUN, pause=1 SHALL hold count_out, generate no expire, and leave the state unchanged.
REQ-026 pause SHALL have no effect in IDLE or DONE.
REQ-027 In DONE, count_out=0 SHALL hold until a start or an abort.
REQ-028 Changes to load_val or periodic after start has been accepted SHALL have no effect until the next accepted start.
REQ-029 The end-to-end latency from start to expire SHALL be load_val+1 edges in one-shot mode (no pause), and the period SHALL be load_val cycles in periodic mode.

Reset
REQ-030 n_rst=0 SHALL asynchronously force state IDLE, count_out=0, busy=0, done=0, expire=0, expire_total=0, latched reload value=0 and latched mode one-shot.
REQ-031 An n_rst assertion mid-RUN SHALL take effect without a clock edge; after release, the block SHALL remain in IDLE until start.

Verification
REQ-032 One-shot: start with load_val=3, periodic=0 -> count_out 3,2,1,0 on successive edges; expire=1 only in the count==0 cycle; done=1 and busy=0 thereafter; expire_total=1.
REQ-033 Periodic: start with load_val=2, periodic=1, run 7 cycles -> count_out 2,1,2,1,2,1,2; expire high on each 1->2 edge (3 pulses); expire_total=3; busy stays 1.
REQ-034 Pause: load_val=5 one-shot, pause=1 for 3 cycles at count_out=3 -> count_out holds 3 for those cycles; expire occurs 3 cycles later than in the unpaused case.
REQ-035 Abort/start: abort at count_out=4 with start=1 in the same cycle -> IDLE and count_out=0 next edge; start while in RUN -> count unaffected.
REQ-036 Zero load: start with load_val=0 -> next edge gives DONE, expire=1 for one cycle, expire_total=1.
REQ-037 Reset mid-run: n_rst=0 asynchronously at count_out=6, periodic=1 -> all outputs 0 immediately; IDLE after release.
REQ-038 Saturation: periodic, load_val=1, run 300 cycles -> expire every cycle; expire_total=255 and no wrap.
